ph_fifo_array: RTL



---
 rtl/ph_fifo_array.sv | 110 +++++++++++
 1 files changed

// File: rtl/ph_fifo_array.sv
// ph_fifo_array: parasite-to-host channel array.
// Channel 0 is a deep FIFO, PAIR_CH is a 2-entry mode register, others are DEPTHN deep.
module ph_fifo_array #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int DEPTH0  = 24,
    parameter int DEPTHN  = 1,
    parameter int PAIR_CH = 2,
    parameter int CW      = 6
) (
    input  logic              h_phi2,
    input  logic              h_rst_b,
    input  logic              h_rd,
    input  logic [NCH-1:0]    h_selectData,
    input  logic [NCH-1:0]    h_flush,
    output logic [DW-1:0]     h_data,
    output logic [NCH-1:0]    h_data_available,
    output logic              h_zero_bytes_available,
    output logic [NCH*CW-1:0] h_count,
    input  logic              p_we,
    input  logic [NCH-1:0]    p_selectData,
    input  logic [DW-1:0]     p_data,
    input  logic              one_byte_mode,
    output logic [NCH-1:0]    p_full
);

    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_push;
    logic [NCH-1:0] w_pop;
    logic [DW-1:0]  w_head [NCH];
    logic [CW-1:0]  w_cnt  [NCH];

    // Host side reads only the lowest selected channel
    assign w_sel  = h_selectData & (~h_selectData + NCH'(1));
    assign w_push = {NCH{p_we}} & p_selectData & ~p_full;
    assign w_pop  = {NCH{h_rd}} & w_sel & h_data_available;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam int D  = (gi == 0) ? DEPTH0 :
                            (gi == PAIR_CH) ? 2 : DEPTHN;
        localparam int AW = (D > 1) ? $clog2(D) : 1;

        logic [DW-1:0] r_mem [D];
        logic [AW-1:0] r_rd_ptr;
        logic [AW-1:0] r_wr_ptr;
        logic [CW-1:0] r_cnt;
        logic [AW-1:0] w_rd_nxt;
        logic [AW-1:0] w_wr_nxt;

        assign w_rd_nxt = (r_rd_ptr == AW'(D - 1)) ? '0 : r_rd_ptr + AW'(1);
        assign w_wr_nxt = (r_wr_ptr == AW'(D - 1)) ? '0 : r_wr_ptr + AW'(1);

        // Circular buffer state; flush discards any same-cycle push or pop
        always_ff @(posedge h_phi2) begin
            if (!h_rst_b) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
                for (int j = 0; j < D; j++) begin
                    r_mem[j] <= '0;
                end
            end else if (h_flush[gi]) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr] <= p_data;
                    r_wr_ptr        <= w_wr_nxt;
                end
                if (w_pop[gi]) begin
                    r_rd_ptr <= w_rd_nxt;
                end
                if (w_push[gi] && !w_pop[gi]) begin
                    r_cnt <= r_cnt + CW'(1);
                end else if (w_pop[gi] && !w_push[gi]) begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end

        assign w_head[gi]            = r_mem[r_rd_ptr];
        assign w_cnt[gi]             = r_cnt;
        assign h_count[gi*CW +: CW]  = r_cnt;

        if (gi == PAIR_CH) begin : g_pair
            logic w_ready;
            assign w_ready = one_byte_mode ? (r_cnt != '0)
                                           : (r_cnt == CW'(2));
            assign h_data_available[gi] = w_ready;
            assign p_full[gi]           = w_ready;
        end else begin : g_fifo
            assign h_data_available[gi] = (r_cnt != '0);
            assign p_full[gi]           = (r_cnt == CW'(D));
        end
    end

    assign h_zero_bytes_available = (w_cnt[PAIR_CH] == '0);

    // Head of the lowest selected channel, zero when none selected
    always_comb begin
        h_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_sel[i]) begin
                h_data = w_head[i];
            end
        end
    end

endmodule
